parity_stream_checker: RTL and testbench

- Parametrised, pipelined successor to the combinational 9-input parity tree (three XOR3 groups folded by a final XOR3).
- Computes per-word parity of a DATA_W-bit stream over a valid/ready handshake and checks it against a sideband parity bit.
- Accumulates parity across multi-beat frames and checks the result against a frame parity bit on the last beat.
- Keeps a saturating error count; sits between the stimulus/data path and the status/monitor logic.

---
 rtl/parity_pkg.sv | 37 +++
 rtl/parity_xor3_tree.sv | 54 +++++
 rtl/parity_stream_checker.sv | 139 +++++++++++++
 tb/tb_parity_stream_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared types and elaboration-time helpers for the pipelined parity stream checker.
// Covers frame state, per-beat sideband, and XOR3 tree sizing.
package parity_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        INFRAME = 1'b1
    } frame_state_e;

    typedef struct packed {
        logic par;
        logic last;
        logic fpar;
        logic mode;
    } sideband_t;

    // Number of XOR3 levels needed to fold n bits down to one.
    function automatic int clog3(input int n);
        int d;
        int p;
        d = 0;
        p = 1;
        while (p < n) begin
            p = p * 3;
            d = d + 1;
        end
        return d;
    endfunction

    function automatic int level_width(input int w, input int k);
        int r;
        r = w;
        for (int i = 0; i < k; i++) r = (r + 2) / 3;
        return r;
    endfunction

endpackage

// File: rtl/parity_xor3_tree.sv
// Width-generic XOR3 reduction tree with STAGES register levels spread evenly
// over the tree; the final level is always registered so the output is a flop.
module parity_xor3_tree
    import parity_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_par
);

    localparam int LEVELS = clog3(WIDTH);

    // Two spare zero bits let the last partial group read past the data safely.
    logic [WIDTH+1:0] node [0:LEVELS];

    assign node[0] = {2'b00, in_data};

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int WO      = level_width(WIDTH, k + 1);
        localparam bit REG_LVL = (((k + 1) * STAGES) / LEVELS) != ((k * STAGES) / LEVELS);

        logic [WIDTH+1:0] red_d;

        // NOTE: assigning a default before the loop keeps every bit driven on
        // every path, so no latch is inferred for the unused upper bits.
        always_comb begin
            red_d = '0;
            for (int j = 0; j < WO; j++) begin
                red_d[j] = node[k][3*j] ^ node[k][3*j+1] ^ node[k][3*j+2];
            end
        end

        if (REG_LVL) begin : g_reg
            logic [WIDTH+1:0] red_q;
            // NOTE: sequential state uses non-blocking assignment so every flop
            // samples pre-edge values regardless of process ordering.
            always_ff @(posedge clk or posedge rst) begin
                if (rst)     red_q <= '0;
                else if (en) red_q <= red_d;
            end
            assign node[k+1] = red_q;
        end else begin : g_comb
            assign node[k+1] = red_d;
        end
    end

    assign out_par = node[LEVELS][0];

endmodule

// File: rtl/parity_stream_checker.sv
// Streaming word/frame parity checker: XOR3 tree plus matching sideband pipeline,
// frame-mode FSM on the input side, frame accumulator and error counter on the output.
module parity_stream_checker
    import parity_pkg::*;
#(
    parameter int DATA_W      = 9,
    parameter int PIPE_STAGES = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_odd,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 in_par,
    input  logic                 in_last,
    input  logic                 in_fpar,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_word_par,
    output logic                 out_word_err,
    output logic                 out_last,
    output logic                 out_frame_par,
    output logic                 out_frame_err,
    input  logic                 clr_cnt,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic en;
    logic accept;
    logic fire;
    logic raw_par;

    frame_state_e state_q, state_d;
    logic         mode_q, mode_d;
    logic         beat_mode;

    logic [PIPE_STAGES-1:0] valid_q, valid_d;
    sideband_t              sb_q [PIPE_STAGES];
    sideband_t              sb_d [PIPE_STAGES];
    sideband_t              sb_in;
    sideband_t              sb_out;

    logic                 acc_q, acc_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_CNT_W:0]   err_sum;

    assign en       = ~(out_valid & ~out_ready);
    assign in_ready = en;
    assign accept   = in_valid & en;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        beat_mode = (state_q == IDLE) ? cfg_odd : mode_q;
        if (accept) begin
            case (state_q)
                IDLE: begin
                    mode_d = cfg_odd;
                    if (!in_last) state_d = INFRAME;
                end
                INFRAME: if (in_last) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    parity_xor3_tree #(
        .WIDTH  (DATA_W),
        .STAGES (PIPE_STAGES)
    ) u_tree (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in_data (in_data),
        .out_par (raw_par)
    );

    assign sb_in = '{par: in_par, last: in_last, fpar: in_fpar, mode: beat_mode};

    // Valid bits and sideband share the tree's enable so bubbles hold in place too.
    always_comb begin
        valid_d = valid_q;
        sb_d    = sb_q;
        if (en) begin
            valid_d[0] = in_valid;
            sb_d[0]    = sb_in;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                valid_d[i] = valid_q[i-1];
                sb_d[i]    = sb_q[i-1];
            end
        end
    end

    assign out_valid     = valid_q[PIPE_STAGES-1];
    assign sb_out        = sb_q[PIPE_STAGES-1];
    assign out_word_par  = raw_par ^ sb_out.mode;
    assign out_word_err  = out_word_par ^ sb_out.par;
    assign out_last      = sb_out.last;
    assign out_frame_par = acc_q ^ out_word_par;
    assign out_frame_err = out_last & (out_frame_par ^ sb_out.fpar);
    assign fire          = out_valid & out_ready;

    assign err_sum = {1'b0, err_cnt_q}
                   + (ERR_CNT_W+1)'(out_word_err)
                   + (ERR_CNT_W+1)'(out_frame_err);

    always_comb begin
        acc_d     = acc_q;
        err_cnt_d = err_cnt_q;
        if (fire) acc_d = out_last ? 1'b0 : out_frame_par;
        if (clr_cnt)   err_cnt_d = '0;
        else if (fire) err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
    end

    assign err_cnt = err_cnt_q;

    // NOTE: the sideband array is reset along with the valid bits because its
    // contents drive outputs directly and must read as zero after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            valid_q   <= '0;
            acc_q     <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) sb_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            valid_q   <= valid_d;
            acc_q     <= acc_d;
            err_cnt_q <= err_cnt_d;
            sb_q      <= sb_d;
        end
    end

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed self-checking bench for parity_stream_checker (DATA_W=9, PIPE_STAGES=2,
// ERR_CNT_W=2 so counter saturation is reachable with a handful of beats).
module tb_parity_stream_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_odd;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic       in_par;
    logic       in_last;
    logic       in_fpar;
    logic       out_valid;
    logic       out_ready;
    logic       out_word_par;
    logic       out_word_err;
    logic       out_last;
    logic       out_frame_par;
    logic       out_frame_err;
    logic       clr_cnt;
    logic [1:0] err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    parity_stream_checker #(
        .DATA_W      (9),
        .PIPE_STAGES (2),
        .ERR_CNT_W   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_odd       (cfg_odd),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_par        (in_par),
        .in_last       (in_last),
        .in_fpar       (in_fpar),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_word_par  (out_word_par),
        .out_word_err  (out_word_err),
        .out_last      (out_last),
        .out_frame_par (out_frame_par),
        .out_frame_err (out_frame_err),
        .clr_cnt       (clr_cnt),
        .err_cnt       (err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_count();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    // One beat through an otherwise empty pipeline; checks latency and all result fields.
    task automatic run_beat(input string tag, input logic [8:0] d, input logic par,
                            input logic last, input logic fpar, input logic odd,
                            input logic ewp, input logic ewe, input logic efp,
                            input logic efe, input logic clr);
        in_data  = d;
        in_par   = par;
        in_last  = last;
        in_fpar  = fpar;
        cfg_odd  = odd;
        in_valid = 1'b1;
        check({tag, " in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check({tag, " early"}, out_valid, 1'b0);
        tick();
        check({tag, " out_valid"}, out_valid, 1'b1);
        check({tag, " word_par"}, out_word_par, ewp);
        check({tag, " word_err"}, out_word_err, ewe);
        check({tag, " last"}, out_last, last);
        check({tag, " frame_par"}, out_frame_par, efp);
        check({tag, " frame_err"}, out_frame_err, efe);
        clr_cnt = clr;
        tick();
        clr_cnt = 1'b0;
    endtask

    logic [8:0] sv_data [0:7];
    logic       sv_par  [0:7];
    int         rx_cyc  [0:7];
    int         sent;
    int         rcvd;
    logic       saw_block;
    logic       quiet;

    initial begin
        rst       = 1'b1;
        cfg_odd   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_par    = 1'b0;
        in_last   = 1'b0;
        in_fpar   = 1'b0;
        out_ready = 1'b1;
        clr_cnt   = 1'b0;
        tick();
        tick();

        check("rst in_ready", in_ready, 1'b1);
        check("rst out_valid", out_valid, 1'b0);
        check("rst word_par", out_word_par, 1'b0);
        check("rst word_err", out_word_err, 1'b0);
        check("rst last", out_last, 1'b0);
        check("rst frame_par", out_frame_par, 1'b0);
        check("rst frame_err", out_frame_err, 1'b0);
        check("rst err_cnt", err_cnt, 2'd0);
        rst = 1'b0;
        tick();

        // Even mode, all ones: nine ones -> parity 1.
        run_beat("even1ff", 9'h1FF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("even1ff err_cnt", err_cnt, 2'd0);

        // Odd mode, zero word: parity 1 against in_par 0 -> word error.
        run_beat("odd000", 9'h000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("odd000 err_cnt", err_cnt, 2'd1);
        clear_count();
        check("clr err_cnt", err_cnt, 2'd0);

        // Three-beat frame: word parities 1,0,1 -> running frame parity 1,1,0.
        run_beat("f3 b0", 9'h001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_beat("f3 b1", 9'h003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_beat("f3 b2", 9'h007, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("f3 err_cnt", err_cnt, 2'd1);

        // Same frame with cfg_odd raised after the first beat: mode must stay even.
        run_beat("tog b0", 9'h001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run_beat("tog b1", 9'h003, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_beat("tog b2", 9'h007, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("tog err_cnt", err_cnt, 2'd2);
        clear_count();

        // Back-to-back single-beat frames with out_ready low in cycles 3..7.
        sv_data = '{9'h001, 9'h003, 9'h007, 9'h0FF, 9'h100, 9'h155, 9'h1AA, 9'h000};
        sv_par  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        sent      = 0;
        rcvd      = 0;
        saw_block = 1'b0;
        for (int i = 0; i < 8; i++) rx_cyc[i] = -1;
        for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
            out_ready = (cyc >= 3 && cyc < 8) ? 1'b0 : 1'b1;
            cfg_odd   = 1'b0;
            if (sent < 8) begin
                in_valid = 1'b1;
                in_data  = sv_data[sent];
                in_par   = sv_par[sent];
                in_fpar  = sv_par[sent];
                in_last  = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                check($sformatf("stream word_par %0d", rcvd), out_word_par, sv_par[rcvd]);
                rx_cyc[rcvd] = cyc;
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream received", rcvd, 8);
        check("stream blocked", saw_block, 1'b1);
        check("stream first after stall", rx_cyc[1], 8);
        check("stream last cycle", rx_cyc[7], 14);
        check("stream err_cnt", err_cnt, 2'd0);

        // Zero word, even, claimed par 1 and fpar 1: +2 per beat, saturating at 3.
        run_beat("sat1", 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("sat1 err_cnt", err_cnt, 2'd2);
        run_beat("sat2", 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("sat2 err_cnt", err_cnt, 2'd3);
        run_beat("sat3", 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        run_beat("sat4", 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("sat4 err_cnt", err_cnt, 2'd3);
        run_beat("clrfire", 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("clrfire err_cnt", err_cnt, 2'd0);

        // Reset mid-frame and mid-pipeline.
        run_beat("prerst", 9'h000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("prerst err_cnt", err_cnt, 2'd2);
        in_data  = 9'h001;
        in_par   = 1'b0;
        in_last  = 1'b0;
        in_fpar  = 1'b0;
        cfg_odd  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst in_ready", in_ready, 1'b1);
        check("midrst err_cnt", err_cnt, 2'd0);
        check("midrst frame_par", out_frame_par, 1'b0);
        tick();
        rst   = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) quiet = 1'b0;
        end
        check("postrst quiet", quiet, 1'b1);
        run_beat("postrst", 9'h001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("postrst err_cnt", err_cnt, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
